chev_keystream_gen: RTL and testbench

// - Iteration controller and keystream extractor wrapped around the degree-3 Chebyshev map stage (chev3D_map).
// - Loads a 32-bit seed and drives the map input with the current state x.
// - Captures the registered map output and feeds it back as the next state.
// - Discards BURN_IN transient iterations, then emits one keystream byte per iteration through a small FIFO with a valid/ready output.

---
 rtl/chev_pkg.sv | 19 +
 rtl/chev_ks_fifo.sv | 53 +++++
 rtl/chev_keystream_gen.sv | 130 +++++++++++++
 tb/tb_chev_keystream_gen.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chev_pkg.sv
// Shared types and constants for the Chebyshev keystream generator.
//   chev_ks_state_t : iteration controller states
//   CHEV_X_W        : state word width
//   CHEV_XN_W       : map stage output width (extra MSB flags overflow)
//   CHEV_SAT        : value substituted for an overflowed map result
package chev_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    STUCK   = 2'd3
  } chev_ks_state_t;

  localparam int CHEV_X_W  = 32;
  localparam int CHEV_XN_W = 33;
  localparam logic [CHEV_X_W-1:0] CHEV_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/chev_ks_fifo.sv
// Small synchronous FIFO holding keystream bytes.
//   clk, rst_n   : clock, async active-low reset
//   clr          : synchronous flush (pointers back to empty)
//   push, wdata  : write strobe / data (caller never pushes when full)
//   pop          : read strobe, advances head (ignored when empty)
//   rdata        : head entry, forced to 0 while empty
//   full, empty  : occupancy flags
module chev_ks_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/chev_keystream_gen.sv
// Iteration controller and keystream extractor around an external
// degree-3 Chebyshev map stage (1-cycle registered latency).
//   clk, rst_n            : clock, async active-low reset
//   seed_valid/seed_ready : seed handshake, seed = initial state x0
//   stop                  : synchronous abort; returns to IDLE, flushes FIFO
//   map_xt                : current state driven to the map stage
//   map_xtn               : map stage result, bit 32 = overflow
//   ks_valid/ks_ready     : keystream byte handshake, ks_data = FIFO head
//   busy                  : controller not idle
//   burn_done             : transient iterations finished for this seed
//   err_stuck             : orbit hit a fixed point (sticky until stop)
module chev_keystream_gen
  import chev_pkg::*;
#(
  parameter int BURN_IN     = 64,
  parameter int EXTRACT_LSB = 8,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 seed_valid,
  output logic                 seed_ready,
  input  logic [CHEV_X_W-1:0]  seed,
  input  logic                 stop,
  output logic [CHEV_X_W-1:0]  map_xt,
  input  logic [CHEV_XN_W-1:0] map_xtn,
  output logic                 ks_valid,
  input  logic                 ks_ready,
  output logic [7:0]           ks_data,
  output logic                 busy,
  output logic                 burn_done,
  output logic                 err_stuck
);

  // Count value on which the last transient iteration completes.
  localparam logic [15:0] BURN_LAST = 16'((BURN_IN == 0) ? 0 : BURN_IN - 1);

  chev_ks_state_t      state, state_n;
  logic [CHEV_X_W-1:0] x_reg, x_n, nx;
  logic [15:0]         burn_cnt, cnt_n;
  logic                bd_n, err_n;
  logic                push, pop, fifo_full, fifo_empty;

  assign map_xt     = x_reg;
  assign busy       = (state != IDLE);
  assign seed_ready = (state == IDLE) && !stop;
  assign nx         = map_xtn[CHEV_X_W] ? CHEV_SAT : map_xtn[CHEV_X_W-1:0];
  assign ks_valid   = !fifo_empty;
  assign pop        = ks_valid && ks_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_reg     <= '0;
      burn_cnt  <= '0;
      burn_done <= 1'b0;
      err_stuck <= 1'b0;
    end else begin
      state     <= state_n;
      x_reg     <= x_n;
      burn_cnt  <= cnt_n;
      burn_done <= bd_n;
      err_stuck <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x_reg;
    cnt_n   = burn_cnt;
    bd_n    = burn_done;
    err_n   = err_stuck;
    push    = 1'b0;
    if (stop) begin
      // x_reg deliberately keeps its value across an abort.
      state_n = IDLE;
      cnt_n   = '0;
      bd_n    = 1'b0;
      err_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (seed_valid) begin
            x_n     = seed;
            cnt_n   = '0;
            bd_n    = (BURN_IN == 0);
            state_n = ISSUE;
          end
        end
        ISSUE: begin
          // Stall while a produced byte would have nowhere to go.
          if (!(burn_done && fifo_full)) state_n = CAPTURE;
        end
        CAPTURE: begin
          if (nx == x_reg) begin
            state_n = STUCK;
            err_n   = 1'b1;
          end else begin
            x_n     = nx;
            state_n = ISSUE;
            if (!burn_done) begin
              cnt_n = burn_cnt + 16'd1;
              if (burn_cnt == BURN_LAST) bd_n = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
        end
        STUCK:   state_n = STUCK;
        default: state_n = IDLE;
      endcase
    end
  end

  chev_ks_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stop),
    .push  (push),
    .pop   (pop),
    .wdata (nx[EXTRACT_LSB +: 8]),
    .rdata (ks_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_chev_keystream_gen.sv
// Self-checking bench for chev_keystream_gen. A registered map stand-in
// (LCG in normal mode, forced overflow or identity in fault modes) feeds
// map_xtn; expected keystream comes from iterating the map from the seed.
module tb_chev_keystream_gen;

  localparam int BURN_IN = 4;
  localparam int LSB     = 8;
  localparam int DEPTH   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_valid = 1'b0;
  logic        stop = 1'b0;
  logic        ks_ready = 1'b0;
  logic [31:0] seed = '0;
  logic        seed_ready, ks_valid, busy, burn_done, err_stuck;
  logic [31:0] map_xt;
  logic [32:0] map_xtn;
  logic [7:0]  ks_data;
  int          mode = 0;  // 0 normal, 1 overflow, 2 identity

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  chev_keystream_gen #(
    .BURN_IN     (BURN_IN),
    .EXTRACT_LSB (LSB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .seed       (seed),
    .stop       (stop),
    .map_xt     (map_xt),
    .map_xtn    (map_xtn),
    .ks_valid   (ks_valid),
    .ks_ready   (ks_ready),
    .ks_data    (ks_data),
    .busy       (busy),
    .burn_done  (burn_done),
    .err_stuck  (err_stuck)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lcg(input logic [31:0] x);
    return x * 32'h0019_660D + 32'h3C6E_F35F;
  endfunction

  function automatic logic [31:0] iter(input logic [31:0] s, input int n);
    logic [31:0] x = s;
    for (int i = 0; i < n; i++) x = lcg(x);
    return x;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) map_xtn <= '0;
    else case (mode)
      0:       map_xtn <= {1'b0, lcg(map_xt)};
      1:       map_xtn <= 33'h1_0000_0000;
      default: map_xtn <= {1'b0, map_xt};
    endcase
  end

  // Keystream = bits of every iterate after the burn-in ones.
  task automatic build_exp(input logic [31:0] s, input int n);
    logic [31:0] x = s;
    int it = 0;
    exp_q.delete();
    while (exp_q.size() < n) begin
      x = lcg(x);
      it++;
      if (it > BURN_IN) exp_q.push_back(x[LSB +: 8]);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  // Present seed for one cycle (cycle 0); returns during cycle 1.
  task automatic do_seed(input logic [31:0] s);
    seed_valid = 1'b1;
    seed = s;
    @(negedge clk);
    chk("seed_ready_on_offer", seed_ready, 1'b1);
    next_cyc();
    seed_valid = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    next_cyc();
    stop = 1'b0;
    @(negedge clk);
    chk("stop_busy", busy, 1'b0);
    chk("stop_ks_valid", ks_valid, 1'b0);
    next_cyc();
  endtask

  // Drain n bytes and compare to exp_q; ks_ready random when rnd.
  task automatic drain(input string tag, input int n, input bit rnd, input int budget);
    int got = 0;
    int cyc = 0;
    bit hold = 0;
    logic [7:0] held = '0;
    while (got < n && cyc < budget) begin
      ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (hold && ks_valid) chk({tag, "_stable"}, ks_data, held);
      hold = ks_valid && !ks_ready;
      held = ks_data;
      if (ks_valid && ks_ready) begin
        chk(tag, ks_data, exp_q.pop_front());
        got++;
      end
      next_cyc();
      cyc++;
    end
    chk({tag, "_count"}, got, n);
  endtask

  initial begin
    logic [31:0] s, xa;
    int first_v, got, cyc;
    bit seen;

    // Reset state
    @(negedge clk);
    chk("rst_seed_ready", seed_ready, 1'b1);
    chk("rst_ks_valid", ks_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_map_xt", map_xt, 32'h0);
    chk("rst_ks_data", ks_data, 8'h0);
    chk("rst_burn_done", burn_done, 1'b0);
    chk("rst_err_stuck", err_stuck, 1'b0);
    next_cyc();
    rst_n = 1'b1;
    repeat (2) next_cyc();
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_seed_ready", seed_ready, 1'b1);
    next_cyc();

    // Directed seed: burn-in timing and first bytes
    ks_ready = 1'b1;
    s = 32'h4000_0000;
    build_exp(s, 10);
    do_seed(s);
    first_v = -1;
    got = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) chk("A_busy", busy, 1'b1);
      if (c == 8) chk("A_burn_done_c8", burn_done, 1'b0);
      if (c == 9) chk("A_burn_done_c9", burn_done, 1'b1);
      if (ks_valid && first_v < 0) first_v = c;
      if (ks_valid && got < 10) begin
        chk("A_ks_data", ks_data, exp_q.pop_front());
        got++;
      end
      next_cyc();
    end
    chk("A_first_valid_cycle", first_v, 11);
    chk("A_byte_count", got, 10);
    stop_pulse();

    // Back-pressure: FIFO fills, ISSUE stalls with x frozen
    ks_ready = 1'b0;
    s = $urandom;
    build_exp(s, 16);
    do_seed(s);
    repeat (40) next_cyc();
    @(negedge clk);
    xa = map_xt;
    chk("B_frozen_x_model", xa, iter(s, BURN_IN + DEPTH));
    repeat (10) next_cyc();
    @(negedge clk);
    chk("B_frozen_x", map_xt, xa);
    chk("B_ks_valid", ks_valid, 1'b1);
    chk("B_busy", busy, 1'b1);
    next_cyc();
    drain("B_ks_data", 16, 1'b0, 200);
    @(negedge clk);
    chk("B_resumed", map_xt != xa, 1'b1);
    next_cyc();
    stop_pulse();

    // Random seeds with random consumer back-pressure
    for (int k = 0; k < 3; k++) begin
      s = $urandom;
      build_exp(s, 12);
      ks_ready = 1'b0;
      do_seed(s);
      drain("C_ks_data", 12, 1'b1, 400);
      stop_pulse();
    end

    // Saturation then identity map -> stuck
    ks_ready = 1'b0;
    s = $urandom;
    do_seed(s);
    repeat (14) next_cyc();
    mode = 1;
    seen = 0;
    cyc = 0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      if (map_xt == 32'hFFFF_FFFF) begin
        seen = 1;
        mode = 2;
      end
      next_cyc();
      cyc++;
    end
    chk("D_saturated", seen, 1'b1);
    seen = 0;
    cyc = 0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      seen = err_stuck;
      next_cyc();
      cyc++;
    end
    chk("D_err_stuck", seen, 1'b1);
    @(negedge clk);
    chk("D_stuck_busy", busy, 1'b1);
    chk("D_stuck_x", map_xt, 32'hFFFF_FFFF);
    chk("D_bytes_queued", ks_valid, 1'b1);
    next_cyc();
    ks_ready = 1'b1;
    repeat (20) next_cyc();
    @(negedge clk);
    chk("D_drained", ks_valid, 1'b0);
    chk("D_err_sticky", err_stuck, 1'b1);
    chk("D_seed_ignored", seed_ready, 1'b0);
    next_cyc();
    mode = 0;
    stop = 1'b1;
    next_cyc();
    stop = 1'b0;
    @(negedge clk);
    chk("D_stop_err_clr", err_stuck, 1'b0);
    chk("D_stop_busy", busy, 1'b0);
    next_cyc();

    // stop in CAPTURE with 3 bytes queued
    ks_ready = 1'b0;
    s = $urandom;
    do_seed(s);
    repeat (15) next_cyc();   // now in cycle 16 (a CAPTURE cycle)
    xa = map_xt;
    chk("E_x_model", xa, iter(s, 7));
    stop = 1'b1;
    @(negedge clk);
    chk("E_queued", ks_valid, 1'b1);
    next_cyc();
    stop = 1'b0;
    @(negedge clk);
    chk("E_busy", busy, 1'b0);
    chk("E_ks_valid", ks_valid, 1'b0);
    chk("E_burn_done", burn_done, 1'b0);
    chk("E_err_stuck", err_stuck, 1'b0);
    chk("E_seed_ready", seed_ready, 1'b1);
    chk("E_x_held", map_xt, xa);
    next_cyc();

    // stop together with seed_valid: seed rejected
    stop = 1'b1;
    seed_valid = 1'b1;
    seed = $urandom;
    @(negedge clk);
    chk("F_seed_ready", seed_ready, 1'b0);
    next_cyc();
    stop = 1'b0;
    seed_valid = 1'b0;
    @(negedge clk);
    chk("F_busy", busy, 1'b0);
    chk("F_x_held", map_xt, xa);
    next_cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
